// File: rtl/bht_update_unit_pkg.sv
// Shared branch-history definitions: table geometry, 2-bit counter encodings
// and the saturating next-state rule used by both the writer and fetch reader.
package bht_pkg;

    localparam int LOWER = 5;
    localparam int ROWS  = 1 << (LOWER - 2);

    typedef enum logic [1:0] {
        SN = 2'b00,
        WN = 2'b01,
        WT = 2'b10,
        ST = 2'b11
    } sat2_t;

    // Step a 2-bit counter one position toward the resolved outcome, saturating at the ends.
    function automatic sat2_t sat2_next(input sat2_t state, input logic outcome);
        sat2_t next_state;
        case (state)
            SN:      next_state = outcome ? WN : SN;
            WN:      next_state = outcome ? WT : SN;
            WT:      next_state = outcome ? ST : WN;
            ST:      next_state = outcome ? ST : WT;
            default: next_state = SN;
        endcase
        return next_state;
    endfunction

endpackage

// File: rtl/bht_update_unit_if.sv
// Bus between EX branch resolution and the BHT writer, carrying the resolved
// outcome in and the prediction vector / mispredict information back out.
interface bht_update_unit_if #(
    parameter int LOWER = 5,
    parameter int ROWS  = 8,
    parameter int CNT_W = 16
);
    logic             en;
    logic             upd_valid;
    logic [LOWER-1:0] upd_addr;
    logic             was_taken;
    logic             jumped;
    logic             pred_taken;
    logic [ROWS-1:0]  pred_vec;
    logic             mispredict;
    logic [CNT_W-1:0] mispred_cnt;

    modport master (
        output en, upd_valid, upd_addr, was_taken, jumped, pred_taken,
        input  pred_vec, mispredict, mispred_cnt
    );

    modport slave (
        input  en, upd_valid, upd_addr, was_taken, jumped, pred_taken,
        output pred_vec, mispredict, mispred_cnt
    );
endinterface

// File: rtl/bht_update_unit_sat_counter.sv
// One 2-bit saturating counter row; the new value is computed by the writer and
// loaded here, reset returns the row to its configured initial state.
module bht_sat_counter
    import bht_pkg::*;
#(
    parameter sat2_t RESET_VAL = SN
) (
    input  logic  clk,
    input  logic  arst_n,
    input  logic  load,
    input  sat2_t d,
    output sat2_t q
);

    sat2_t state_q;
    sat2_t state_d;

    // Take the new counter value only when this row is the one being written.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = d;
        end
    end

    // Counter storage with asynchronous return to the row's initial value.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= RESET_VAL;
        end else begin
            state_q <= state_d;
        end
    end

    assign q = state_q;

endmodule

// File: rtl/bht_update_unit.sv
// Write side of the 2-bit branch history table: a two-stage read-modify-write of
// the addressed counter, with a bypass so back-to-back updates to one row never
// see a stale value, plus mispredict pulse and saturating mispredict count.
module bht_update_unit
    import bht_pkg::*;
#(
    parameter int                  CNT_W       = 16,
    parameter logic [2*ROWS-1:0]   INIT_STATES = 16'h0200
) (
    input logic               clk,
    input logic               arst_n,
    bht_update_unit_if.slave  bus
);

    localparam int ROW_W = LOWER - 2;

    sat2_t             cnt_q [ROWS];
    logic [ROWS-1:0]   load;
    logic [ROWS-1:0]   pred_vec;
    sat2_t             wr_state;
    logic              s2_fire;
    logic [ROW_W-1:0]  in_row;
    logic              in_outcome;
    logic              unused_addr_bits;

    logic              s1_valid_q,   s1_valid_d;
    logic [ROW_W-1:0]  s1_row_q,     s1_row_d;
    logic              s1_outcome_q, s1_outcome_d;
    logic              s1_pred_q,    s1_pred_d;
    sat2_t             s1_state_q,   s1_state_d;
    logic              mispredict_q, mispredict_d;
    logic [CNT_W-1:0]  mispred_cnt_q, mispred_cnt_d;

    assign in_row           = bus.upd_addr[LOWER-1:2];
    assign in_outcome       = bus.was_taken | bus.jumped;
    assign unused_addr_bits = ^bus.upd_addr[1:0];
    assign s2_fire          = bus.en & s1_valid_q;
    assign wr_state         = sat2_next(s1_state_q, s1_outcome_q);

    genvar gi;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_row
            bht_sat_counter #(
                .RESET_VAL(sat2_t'(INIT_STATES[2*gi +: 2]))
            ) u_cnt (
                .clk    (clk),
                .arst_n (arst_n),
                .load   (load[gi]),
                .d      (wr_state),
                .q      (cnt_q[gi])
            );
        end
    endgenerate

    // Row write strobe, stage-1 capture with same-row bypass, and mispredict bookkeeping.
    always_comb begin
        load          = '0;
        s1_valid_d    = s1_valid_q;
        s1_row_d      = s1_row_q;
        s1_outcome_d  = s1_outcome_q;
        s1_pred_d     = s1_pred_q;
        s1_state_d    = s1_state_q;
        mispredict_d  = s2_fire & (s1_outcome_q != s1_pred_q);
        mispred_cnt_d = mispred_cnt_q;

        if (s2_fire) begin
            load[s1_row_q] = 1'b1;
        end
        if (mispredict_d && (mispred_cnt_q != {CNT_W{1'b1}})) begin
            mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
        end
        if (bus.en) begin
            s1_valid_d   = bus.upd_valid;
            s1_row_d     = in_row;
            s1_outcome_d = in_outcome;
            s1_pred_d    = bus.pred_taken;
            if (s2_fire && (s1_row_q == in_row)) begin
                s1_state_d = wr_state;
            end else begin
                s1_state_d = cnt_q[in_row];
            end
        end
    end

    // Pipeline and mispredict registers; reset drops any in-flight update.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            s1_valid_q    <= 1'b0;
            s1_row_q      <= '0;
            s1_outcome_q  <= 1'b0;
            s1_pred_q     <= 1'b0;
            s1_state_q    <= SN;
            mispredict_q  <= 1'b0;
            mispred_cnt_q <= '0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_row_q      <= s1_row_d;
            s1_outcome_q  <= s1_outcome_d;
            s1_pred_q     <= s1_pred_d;
            s1_state_q    <= s1_state_d;
            mispredict_q  <= mispredict_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    // Prediction vector is the MSB of each counter flop, so it is purely registered.
    always_comb begin
        pred_vec = '0;
        for (int i = 0; i < ROWS; i++) begin
            pred_vec[i] = cnt_q[i][1];
        end
    end

    assign bus.pred_vec    = pred_vec;
    assign bus.mispredict  = mispredict_q;
    assign bus.mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_bht_update_unit.sv
// Randomised and directed checking of bht_update_unit against an in-bench
// behavioural model of the branch history table.
module tb_bht_update_unit;

    localparam int          TB_CNT_W  = 4;
    localparam int          CNT_MAX   = (1 << TB_CNT_W) - 1;
    localparam logic [15:0] TB_INIT   = 16'h0200;

    logic clk;
    logic arst_n;

    bht_update_unit_if #(.LOWER(5), .ROWS(8), .CNT_W(TB_CNT_W)) ifc ();

    bht_update_unit #(
        .CNT_W       (TB_CNT_W),
        .INIT_STATES (TB_INIT)
    ) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (ifc.slave)
    );

    int testsRun    = 0;
    int testsFailed = 0;
    bit checkOn     = 0;

    // Model: counter values as plain integers 0..3, one pending update awaiting its write.
    int mCnt [8];
    bit pendValid;
    int pendRow;
    bit pendOut;
    bit pendPred;
    bit expMisp;
    int expCnt;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] expVec();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) begin
            v[i] = (mCnt[i] >= 2);
        end
        return v;
    endfunction

    task automatic modelReset();
        logic [15:0] init;
        init = TB_INIT;
        for (int i = 0; i < 8; i++) begin
            mCnt[i] = int'(init[2*i +: 2]);
        end
        pendValid = 0;
        pendRow   = 0;
        pendOut   = 0;
        pendPred  = 0;
        expMisp   = 0;
        expCnt    = 0;
    endtask

    task automatic modelStep();
        expMisp = 0;
        if (!ifc.en) begin
            return;
        end
        if (pendValid) begin
            if (pendOut) begin
                mCnt[pendRow] = (mCnt[pendRow] == 3) ? 3 : mCnt[pendRow] + 1;
            end else begin
                mCnt[pendRow] = (mCnt[pendRow] == 0) ? 0 : mCnt[pendRow] - 1;
            end
            expMisp = (pendOut != pendPred);
            if (expMisp && expCnt < CNT_MAX) begin
                expCnt++;
            end
        end
        pendValid = ifc.upd_valid;
        pendRow   = int'(ifc.upd_addr) >> 2;
        pendOut   = ifc.was_taken | ifc.jumped;
        pendPred  = ifc.pred_taken;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, let the clock edge land, and advance the model.
    task automatic applyStimulus(input bit en, input bit valid, input logic [4:0] addr,
                                 input bit wt, input bit jmp, input bit pt);
        ifc.en         = en;
        ifc.upd_valid  = valid;
        ifc.upd_addr   = addr;
        ifc.was_taken  = wt;
        ifc.jumped     = jmp;
        ifc.pred_taken = pt;
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus(1, 0, 5'h00, 0, 0, 0);
        end
    endtask

    // Every cycle the outputs are live, compare them with the model.
    always @(negedge clk) begin
        if (checkOn) begin
            checkOutput("pred_vec",    32'(ifc.pred_vec),    32'(expVec()));
            checkOutput("mispredict",  32'(ifc.mispredict),  32'(expMisp));
            checkOutput("mispred_cnt", 32'(ifc.mispred_cnt), 32'(expCnt));
        end
    end

    initial begin
        arst_n = 1'b0;
        ifc.en = 0; ifc.upd_valid = 0; ifc.upd_addr = '0;
        ifc.was_taken = 0; ifc.jumped = 0; ifc.pred_taken = 0;
        modelReset();
        repeat (2) @(posedge clk);
        #2 arst_n = 1'b1;
        checkOn = 1;
        @(negedge clk); #1;
        checkOutput("reset_pred_vec", 32'(ifc.pred_vec), 32'h10);
        checkOutput("reset_cnt",      32'(ifc.mispred_cnt), 32'd0);

        // Row 4 not taken while predicted taken
        applyStimulus(1, 1, 5'h10, 0, 0, 1);
        idle(1);
        checkOutput("row4_nt_vec",  32'(ifc.pred_vec), 32'h00);
        checkOutput("row4_nt_misp", 32'(ifc.mispredict), 32'd1);
        checkOutput("row4_nt_cnt",  32'(ifc.mispred_cnt), 32'd1);
        idle(1);
        checkOutput("row4_nt_pulse_end", 32'(ifc.mispredict), 32'd0);

        // Four back-to-back taken updates to row 0
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 1, 5'h00, 1, 0, 0);
        end
        idle(2);
        checkOutput("row0_bypass_vec", 32'(ifc.pred_vec), 32'h01);
        checkOutput("row0_bypass_cnt", 32'(ifc.mispred_cnt), 32'd5);

        // Jump on row 2, correctly predicted
        applyStimulus(1, 1, 5'h08, 0, 1, 1);
        idle(2);
        checkOutput("jump_vec", 32'(ifc.pred_vec), 32'h01);
        checkOutput("jump_cnt", 32'(ifc.mispred_cnt), 32'd5);

        // Update held in stage 1 across three frozen cycles
        applyStimulus(1, 1, 5'h10, 1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 5'h00, 0, 0, 0);
        end
        checkOutput("freeze_vec", 32'(ifc.pred_vec), 32'h01);
        applyStimulus(1, 0, 5'h00, 0, 0, 0);
        checkOutput("resume_vec",  32'(ifc.pred_vec), 32'h11);
        checkOutput("resume_misp", 32'(ifc.mispredict), 32'd1);
        checkOutput("resume_cnt",  32'(ifc.mispred_cnt), 32'd6);

        // Reset between stage 1 and stage 2 drops the update
        applyStimulus(1, 1, 5'h04, 1, 0, 0);
        arst_n = 1'b0;
        modelReset();
        @(posedge clk); #1;
        arst_n = 1'b1;
        idle(2);
        checkOutput("midreset_vec",  32'(ifc.pred_vec), 32'h10);
        checkOutput("midreset_misp", 32'(ifc.mispredict), 32'd0);
        checkOutput("midreset_cnt",  32'(ifc.mispred_cnt), 32'd0);

        // Counter saturation: 2**CNT_W+2 mispredicts
        for (int k = 0; k < CNT_MAX + 3; k++) begin
            applyStimulus(1, 1, 5'($urandom_range(0, 31)), 1, 0, 0);
        end
        idle(2);
        checkOutput("sat_cnt", 32'(ifc.mispred_cnt), 32'd15);

        // Randomised traffic, with occasional freezes
        arst_n = 1'b0;
        modelReset();
        @(posedge clk); #1;
        arst_n = 1'b1;
        for (int k = 0; k < 400; k++) begin
            applyStimulus(($urandom_range(0, 9) != 0), 1'($urandom),
                          5'($urandom_range(0, 31)), 1'($urandom),
                          ($urandom_range(0, 7) == 0), 1'($urandom));
        end
        idle(3);

        checkOn = 0;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
